// File: rtl/ecc_pkg.sv
// Shared SECDED definitions for the ECC FIFO read path: word geometry,
// check-bit and data-bit position maps, status encoding and data extraction.
package ecc_pkg;

   localparam int DATA_W  = 32;
   localparam int WORD_W  = 39;
   localparam int SYN_W   = 6;
   localparam int MAX_POS = 38;

   // Hamming positions of the check bits; each value is also the mask that
   // selects the group of positions that check bit covers.
   localparam int CHECK_POS [SYN_W] = '{1, 2, 4, 8, 16, 32};

   // Hamming position of each data bit d0..d31 (all non-power-of-two positions).
   localparam int DATA_POS [DATA_W] = '{
       3,  5,  6,  7,  9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21,
      22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 33, 34, 35, 36, 37, 38
   };

   typedef enum logic [1:0] {
      ECC_CLEAN,
      ECC_SEC,
      ECC_DED
   } ecc_status_e;

   // Pull the 32 payload bits out of an encoded word.
   function automatic logic [DATA_W-1:0] extract_data(input logic [WORD_W-1:0] word);
      logic [DATA_W-1:0] data;
      data = '0;
      for (int i = 0; i < DATA_W; i++) begin
         data[i] = word[DATA_POS[i]];
      end
      return data;
   endfunction

   // Map syndrome and overall parity onto the decode outcome.
   function automatic ecc_status_e classify(input logic [SYN_W-1:0] syndrome,
                                            input logic               parity);
      ecc_status_e status;
      status = ECC_CLEAN;
      if (parity) begin
         if (syndrome <= SYN_W'(MAX_POS)) status = ECC_SEC;
         else                             status = ECC_DED;
      end else if (syndrome != '0) begin
         status = ECC_DED;
      end
      return status;
   endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational Hamming syndrome and overall-parity generator for one
// 39-bit SECDED word. Shared between the read decoder and a scrubber.
module ecc_syndrome_calc
   import ecc_pkg::*;
(
   input  logic [WORD_W-1:0] word_i,
   output logic [SYN_W-1:0]  syndrome_o,
   output logic              parity_o
);

   // Fold every position 1..MAX_POS into each check group it belongs to.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned; a missing default in always_comb infers a latch.
      syndrome_o = '0;
      for (int k = 0; k < SYN_W; k++) begin
         for (int p = 1; p <= MAX_POS; p++) begin
            if ((p & CHECK_POS[k]) != 0) begin
               syndrome_o[k] = syndrome_o[k] ^ word_i[p];
            end
         end
      end
   end

   // Overall parity covers all 39 bits including bit 0.
   assign parity_o = ^word_i;

endmodule

// File: rtl/ecc_rd_decoder.sv
// Read-side SECDED checker/corrector for the ECC-protected FIFO.
// Two registered stages: stage 1 captures the memory read, stage 2 decodes
// and registers corrected data plus status. Saturating SEC/DED counters and
// a sticky DED flag feed status logic.
// Optional build macro ECC_ERR_ADDR_LOG_EN adds a first-error address log
// (err_addr_o / err_addr_vld_o).
module ecc_rd_decoder
   import ecc_pkg::*;
#(
   parameter int DATA_WIDTH        = 32,
   parameter int MEMORY_DATA_WIDTH = 39,
   parameter int ADDR_WIDTH        = 5,
   parameter int PARITY_BITS       = 6,
   parameter int CNT_WIDTH         = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         rd_valid_i,
   input  logic [ADDR_WIDTH-1:0]        rd_addr_i,
   input  logic [MEMORY_DATA_WIDTH-1:0] rd_data_i,
   input  logic                         err_cnt_clr_i,
   output logic                         rd_valid_o,
   output logic [DATA_WIDTH-1:0]        rd_data_o,
   output logic                         sec_err_o,
   output logic                         ded_err_o,
   output logic [PARITY_BITS-1:0]       syndrome_o,
   output logic [CNT_WIDTH-1:0]         sec_cnt_o,
   output logic [CNT_WIDTH-1:0]         ded_cnt_o,
   output logic                         ded_sticky_o
`ifdef ECC_ERR_ADDR_LOG_EN
   ,
   output logic [ADDR_WIDTH-1:0]        err_addr_o,
   output logic                         err_addr_vld_o
`endif
);

   // ---------------- Stage 1: capture memory read ----------------
   logic                         s1_valid;
   logic [ADDR_WIDTH-1:0]        s1_addr;
   logic [MEMORY_DATA_WIDTH-1:0] s1_data;

   // Stage-1 valid, cleared by reset so in-flight words are dropped.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values; blocking here would create
      // order-dependent races between always_ff blocks.
      if (rst_i) s1_valid <= 1'b0;
      else       s1_valid <= rd_valid_i;
   end

   // Stage-1 payload and address capture.
   always_ff @(posedge clk_i) begin
      // NOTE: payload registers carry no reset; they are only consumed when
      // the matching valid is set, and skipping reset keeps the datapath lean.
      s1_addr <= rd_addr_i;
      s1_data <= rd_data_i;
   end

   // ---------------- Stage 2: decode ----------------
   logic [SYN_W-1:0]  syn;
   logic              par;
   ecc_status_e       status;
   logic [WORD_W-1:0] fixed_word;
   logic [DATA_W-1:0] dec_data;

   ecc_syndrome_calc u_syndrome (
      .word_i     (s1_data),
      .syndrome_o (syn),
      .parity_o   (par)
   );

   // Classify the word and flip the faulty bit for a correctable error.
   always_comb begin
      status     = classify(syn, par);
      fixed_word = s1_data;
      if (status == ECC_SEC && syn != '0) begin
         fixed_word = s1_data ^ (WORD_W'(1) << syn);
      end
      dec_data = extract_data(fixed_word);
   end

   // Output register; data and syndrome hold while no word is presented.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_valid_o <= 1'b0;
         sec_err_o  <= 1'b0;
         ded_err_o  <= 1'b0;
         rd_data_o  <= '0;
         syndrome_o <= '0;
      end else begin
         rd_valid_o <= s1_valid;
         sec_err_o  <= s1_valid && (status == ECC_SEC);
         ded_err_o  <= s1_valid && (status == ECC_DED);
         if (s1_valid) begin
            rd_data_o  <= dec_data;
            syndrome_o <= syn;
         end
      end
   end

   // ---------------- Error statistics ----------------
   logic sec_evt;
   logic ded_evt;

   assign sec_evt = rd_valid_o & sec_err_o;
   assign ded_evt = rd_valid_o & ded_err_o;

   // Saturating counters and sticky flag; a clear coinciding with an event
   // keeps that event.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sec_cnt_o    <= '0;
         ded_cnt_o    <= '0;
         ded_sticky_o <= 1'b0;
      end else if (err_cnt_clr_i) begin
         sec_cnt_o    <= sec_evt ? CNT_WIDTH'(1) : '0;
         ded_cnt_o    <= ded_evt ? CNT_WIDTH'(1) : '0;
         ded_sticky_o <= ded_evt;
      end else begin
         if (sec_evt && sec_cnt_o != '1) sec_cnt_o <= sec_cnt_o + 1'b1;
         if (ded_evt && ded_cnt_o != '1) ded_cnt_o <= ded_cnt_o + 1'b1;
         if (ded_evt)                    ded_sticky_o <= 1'b1;
      end
   end

`ifdef ECC_ERR_ADDR_LOG_EN
   // ---------------- First-error address log ----------------
   logic [ADDR_WIDTH-1:0] s2_addr;
   logic                  log_is_ded;

   // Address travels alongside the stage-2 data.
   always_ff @(posedge clk_i) begin
      if (rst_i)         s2_addr <= '0;
      else if (s1_valid) s2_addr <= s1_addr;
   end

   // Keep the first error address; a DED may replace a logged SEC but a
   // logged DED is final until clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_addr_o     <= '0;
         err_addr_vld_o <= 1'b0;
         log_is_ded     <= 1'b0;
      end else if (err_cnt_clr_i) begin
         err_addr_o     <= (sec_evt || ded_evt) ? s2_addr : '0;
         err_addr_vld_o <= sec_evt || ded_evt;
         log_is_ded     <= ded_evt;
      end else if ((sec_evt || ded_evt) &&
                   (!err_addr_vld_o || (ded_evt && !log_is_ded))) begin
         err_addr_o     <= s2_addr;
         err_addr_vld_o <= 1'b1;
         log_is_ded     <= ded_evt;
      end
   end
`else
   // Without the log the stage-1 address has no consumer.
   logic unused_addr;
   assign unused_addr = ^s1_addr;
`endif

endmodule

// File: tb/tb_ecc_rd_decoder.sv
// Self-checking bench for ecc_rd_decoder: directed vector table, counter
// saturation/clear sequence, randomized scoreboard against an index-XOR
// SECDED model, and reset-drop check.
module tb_ecc_rd_decoder;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        rd_valid_i;
   logic [4:0]  rd_addr_i;
   logic [38:0] rd_data_i;
   logic        err_cnt_clr_i;
   logic        rd_valid_o;
   logic [31:0] rd_data_o;
   logic        sec_err_o;
   logic        ded_err_o;
   logic [5:0]  syndrome_o;
   logic [7:0]  sec_cnt_o;
   logic [7:0]  ded_cnt_o;
   logic        ded_sticky_o;
`ifdef ECC_ERR_ADDR_LOG_EN
   logic [4:0]  err_addr_o;
   logic        err_addr_vld_o;
`endif

   always #5 clk = ~clk;

   ecc_rd_decoder dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .rd_valid_i    (rd_valid_i),
      .rd_addr_i     (rd_addr_i),
      .rd_data_i     (rd_data_i),
      .err_cnt_clr_i (err_cnt_clr_i),
      .rd_valid_o    (rd_valid_o),
      .rd_data_o     (rd_data_o),
      .sec_err_o     (sec_err_o),
      .ded_err_o     (ded_err_o),
      .syndrome_o    (syndrome_o),
      .sec_cnt_o     (sec_cnt_o),
      .ded_cnt_o     (ded_cnt_o),
      .ded_sticky_o  (ded_sticky_o)
`ifdef ECC_ERR_ADDR_LOG_EN
      ,
      .err_addr_o     (err_addr_o),
      .err_addr_vld_o (err_addr_vld_o)
`endif
   );

   int tests  = 0;
   int failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- Reference model ----------------
   typedef struct packed {
      logic [31:0] data;
      logic        sec;
      logic        ded;
      logic [5:0]  syn;
   } res_t;

   function automatic bit is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   // Encode: scatter data over non-power-of-two positions, then choose the
   // check bits so the XOR of all set-bit indices becomes zero.
   function automatic logic [38:0] encode(input logic [31:0] d);
      logic [38:0] w;
      int j;
      int x;
      w = '0;
      j = 0;
      x = 0;
      for (int p = 1; p <= 38; p++) begin
         if (!is_pow2(p)) begin
            w[p] = d[j];
            j++;
         end
      end
      for (int p = 1; p <= 38; p++) if (w[p]) x = x ^ p;
      for (int k = 0; k < 6; k++) w[1 << k] = x[k];
      w[0] = ^w[38:1];
      return w;
   endfunction

   // Decode: syndrome is the XOR of the indices of all set bits 1..38.
   function automatic res_t model(input logic [38:0] w_in);
      res_t r;
      logic [38:0] w;
      int x;
      int j;
      bit odd;
      w   = w_in;
      x   = 0;
      odd = ($countones(w) % 2) == 1;
      for (int p = 1; p <= 38; p++) if (w[p]) x = x ^ p;
      r.syn = x[5:0];
      r.sec = odd && (x <= 38);
      r.ded = (!odd && x != 0) || (odd && x > 38);
      if (r.sec && x != 0) w[x] = ~w[x];
      j = 0;
      r.data = '0;
      for (int p = 1; p <= 38; p++) begin
         if (!is_pow2(p)) begin
            r.data[j] = w[p];
            j++;
         end
      end
      return r;
   endfunction

   // ---------------- Directed vectors ----------------
   typedef struct {
      string       name;
      logic [31:0] data;
      logic [38:0] flips;
      logic [31:0] exp_data;
      logic        exp_sec;
      logic        exp_ded;
      logic [5:0]  exp_syn;
   } vec_t;

   vec_t vecs [9];

   typedef struct {
      res_t res;
      int   cyc;
   } exp_t;

   exp_t exp_q [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single-pulse word; checks latency of exactly two cycles.
   task automatic send_check(input string name, input logic [38:0] w, input res_t e);
      rd_valid_i = 1'b1;
      rd_data_i  = w;
      rd_addr_i  = 5'(name.len());
      tick();
      rd_valid_i = 1'b0;
      check({name, "_early"}, rd_valid_o, 1'b0);
      tick();
      check({name, "_valid"}, rd_valid_o, 1'b1);
      check({name, "_out"}, {rd_data_o, sec_err_o, ded_err_o, syndrome_o}, e);
   endtask

   initial begin
      res_t r;
      logic [38:0] w;
      int   m_sec;
      int   m_ded;
      bit   m_sticky;
      int   cyc;

      vecs[0] = '{"clean",     32'hDEADBEEF, 39'h0,                      32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
      vecs[1] = '{"flip3",     32'hDEADBEEF, 39'h1 << 3,                 32'hDEADBEEF, 1'b1, 1'b0, 6'd3};
      vecs[2] = '{"flip0",     32'hDEADBEEF, 39'h1,                      32'hDEADBEEF, 1'b1, 1'b0, 6'd0};
      vecs[3] = '{"flip5_17",  32'hDEADBEEF, (39'h1 << 5) | (39'h1 << 17), 32'hDEADB6ED, 1'b0, 1'b1, 6'd20};
      vecs[4] = '{"flip32_4_3",32'hDEADBEEF, (39'h1 << 32) | (39'h1 << 4) | (39'h1 << 3), 32'hDEADBEEE, 1'b0, 1'b1, 6'd39};
      vecs[5] = '{"flip38",    32'hDEADBEEF, 39'h1 << 38,                32'hDEADBEEF, 1'b1, 1'b0, 6'd38};
      vecs[6] = '{"zero",      32'h00000000, 39'h0,                      32'h00000000, 1'b0, 1'b0, 6'd0};
      vecs[7] = '{"ones_flip1",32'hFFFFFFFF, 39'h1 << 1,                 32'hFFFFFFFF, 1'b1, 1'b0, 6'd1};
      vecs[8] = '{"flip1_2",   32'h12345678, (39'h1 << 1) | (39'h1 << 2), 32'h12345678, 1'b0, 1'b1, 6'd3};

      rst_i         = 1'b1;
      rd_valid_i    = 1'b0;
      rd_addr_i     = '0;
      rd_data_i     = '0;
      err_cnt_clr_i = 1'b0;
      tick();
      tick();
      check("reset_outputs",
            {rd_valid_o, rd_data_o, sec_err_o, ded_err_o, syndrome_o, sec_cnt_o, ded_cnt_o, ded_sticky_o},
            '0);
      rst_i = 1'b0;
      tick();

      // Directed table
      for (int i = 0; i < 9; i++) begin
         send_check(vecs[i].name, encode(vecs[i].data) ^ vecs[i].flips,
                    {vecs[i].exp_data, vecs[i].exp_sec, vecs[i].exp_ded, vecs[i].exp_syn});
         tick();
      end
      check("hold_after_table", {rd_valid_o, sec_err_o, ded_err_o, rd_data_o, syndrome_o},
            {3'b000, 32'h12345678, 6'd3});
      check("table_sec_cnt", sec_cnt_o, 8'd4);
      check("table_ded_cnt", ded_cnt_o, 8'd3);
      check("table_sticky",  ded_sticky_o, 1'b1);

      // Clear with no event present
      err_cnt_clr_i = 1'b1;
      tick();
      err_cnt_clr_i = 1'b0;
      check("clear_cnts", {sec_cnt_o, ded_cnt_o, ded_sticky_o}, '0);

      // Saturation: 300 back-to-back SEC words
      for (int i = 0; i < 300; i++) begin
         rd_valid_i = 1'b1;
         rd_data_i  = encode(32'(i * 32'h9E3779B1)) ^ (39'h1 << 3);
         tick();
      end
      rd_valid_i = 1'b0;
      tick();
      tick();
      tick();
      check("sec_saturate", sec_cnt_o, 8'd255);
      check("sec_sat_no_ded", ded_cnt_o, 8'd0);

      // Clear together with one SEC event: counter loads 1
      rd_valid_i = 1'b1;
      rd_data_i  = encode(32'hCAFEF00D) ^ (39'h1 << 20);
      tick();
      rd_valid_i = 1'b0;
      tick();
      check("clr_evt_present", {rd_valid_o, sec_err_o}, 2'b11);
      err_cnt_clr_i = 1'b1;
      tick();
      err_cnt_clr_i = 1'b0;
      check("clr_with_sec", {sec_cnt_o, ded_cnt_o, ded_sticky_o}, {8'd1, 8'd0, 1'b0});

      // Clear together with one DED event: sticky reflects it
      rd_valid_i = 1'b1;
      rd_data_i  = encode(32'h0BADCAFE) ^ (39'h1 << 9) ^ (39'h1 << 30);
      tick();
      rd_valid_i = 1'b0;
      tick();
      err_cnt_clr_i = 1'b1;
      tick();
      err_cnt_clr_i = 1'b0;
      check("clr_with_ded", {sec_cnt_o, ded_cnt_o, ded_sticky_o}, {8'd0, 8'd1, 1'b1});
      tick();
      check("sticky_holds", ded_sticky_o, 1'b1);

      // Randomized stream against the model
      err_cnt_clr_i = 1'b1;
      tick();
      err_cnt_clr_i = 1'b0;
      m_sec    = 0;
      m_ded    = 0;
      m_sticky = 1'b0;
      cyc      = 0;
      for (int i = 0; i < 420; i++) begin
         if (rd_valid_o) begin
            if (exp_q.size() == 0) begin
               check("rand_spurious", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rand_word", {rd_data_o, sec_err_o, ded_err_o, syndrome_o}, e.res);
               check("rand_latency", 64'(cyc), 64'(e.cyc + 2));
            end
         end else begin
            check("rand_idle_flags", {sec_err_o, ded_err_o}, 2'b00);
         end
         check("rand_cnts", {sec_cnt_o, ded_cnt_o, ded_sticky_o},
               {8'(m_sec), 8'(m_ded), m_sticky});
         if (rd_valid_o) begin
            if (sec_err_o && m_sec < 255) m_sec++;
            if (ded_err_o && m_ded < 255) m_ded++;
            if (ded_err_o)                m_sticky = 1'b1;
         end
         if (i < 400 && $urandom_range(0, 3) != 0) begin
            w = encode($urandom);
            for (int n = $urandom_range(0, 3); n > 0; n--) w[$urandom_range(0, 38)] ^= 1'b1;
            rd_valid_i = 1'b1;
            rd_data_i  = w;
            rd_addr_i  = 5'($urandom);
            exp_q.push_back('{model(w), cyc});
         end else begin
            rd_valid_i = 1'b0;
         end
         tick();
         cyc++;
      end
      check("rand_drained", 64'(exp_q.size()), 64'd0);

      // Reset the cycle after a word is accepted: the word never emerges
      rd_valid_i = 1'b1;
      rd_data_i  = encode(32'h5A5A5A5A) ^ (39'h1 << 7);
      tick();
      rd_valid_i = 1'b0;
      rst_i      = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("rst_drop",
               {rd_valid_o, rd_data_o, sec_err_o, ded_err_o, syndrome_o, sec_cnt_o, ded_cnt_o, ded_sticky_o},
               '0);
         tick();
      end

      // First word after reset: two-cycle latency
      w = encode(32'h600DF00D) ^ (39'h1 << 11);
      send_check("post_rst", w, model(w));
      tick();
      check("post_rst_cnt", sec_cnt_o, 8'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
